reorder_buffer: RTL

- Commit-side counterpart of the rename stage: allocates one ROB slot per renamed instruction, records completion from writeback, and retires in program order.
- Drives the commit interface back into rename (commit_en, commit_old_preg) so old physical registers return to the free list.
- Sits between rename/dispatch and the future issue/writeback stages.
- Supports partial squash on a branch mispredict.

---
 rtl/rob_pkg.sv | 23 ++
 rtl/reorder_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_TAG_W = 4;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned PC_W      = 9;
  localparam int unsigned ARCH_W    = 5;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;
  // Tag plus a wrap bit in the MSB
  typedef logic [ROB_TAG_W:0]   rob_ptr_t;
  typedef logic [PREG_W-1:0]    preg_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [ARCH_W-1:0] rd;
    preg_t             prd;
    preg_t             old_prd;
    logic              reg_write;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates slots at dispatch, marks completion from writeback,
// retires in program order and squashes younger entries on a branch mispredict.
// Optional macro ROB_STATS_EN adds commit and full-stall performance counters.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  output logic [ROB_TAG_W-1:0] dispatch_tag,
  input  logic [PC_W-1:0]      dispatch_pc,
  input  logic [ARCH_W-1:0]    dispatch_rd,
  input  logic [PREG_W-1:0]    dispatch_prd,
  input  logic [PREG_W-1:0]    dispatch_old_prd,
  input  logic                 dispatch_reg_write,
  input  logic                 wb_valid,
  input  logic [ROB_TAG_W-1:0] wb_tag,
  input  logic                 branch_mispredict,
  input  logic [ROB_TAG_W-1:0] mispredict_tag,
  output logic                 commit_en,
  output logic [ROB_TAG_W-1:0] commit_tag,
  output logic [PC_W-1:0]      commit_pc,
  output logic [ARCH_W-1:0]    commit_rd,
  output logic [PREG_W-1:0]    commit_prd,
  output logic [PREG_W-1:0]    commit_old_preg,
  output logic                 commit_reg_write,
  output logic [ROB_TAG_W:0]   rob_count,
  output logic                 rob_empty,
  output logic                 rob_full
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]          perf_commit_cnt,
  output logic [31:0]          perf_full_stall_cnt
`endif
);

  rob_ptr_t             head_q, head_d;
  rob_ptr_t             tail_q, tail_d;
  logic [ROB_DEPTH-1:0] valid_q, valid_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  rob_entry_t           entries_q [ROB_DEPTH];

  rob_tag_t head_idx;
  rob_tag_t tail_idx;
  rob_ptr_t bm_ptr;
  rob_tag_t bm_off;
  logic     dispatch_fire;
  logic     mp_fire;

  assign head_idx = head_q[ROB_TAG_W-1:0];
  assign tail_idx = tail_q[ROB_TAG_W-1:0];

  assign rob_count = tail_q - head_q;
  assign rob_empty = (head_q == tail_q);
  assign rob_full  = (head_idx == tail_idx) && (head_q[ROB_TAG_W] != tail_q[ROB_TAG_W]);

  // No commit bypass: a slot freed this cycle is only reusable next cycle
  assign dispatch_ready = !rob_full && !branch_mispredict;
  assign dispatch_tag   = tail_idx;
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  assign commit_en        = !rob_empty && valid_q[head_idx] && done_q[head_idx];
  assign commit_tag       = head_idx;
  assign commit_pc        = entries_q[head_idx].pc;
  assign commit_rd        = entries_q[head_idx].rd;
  assign commit_prd       = entries_q[head_idx].prd;
  assign commit_old_preg  = entries_q[head_idx].old_prd;
  assign commit_reg_write = entries_q[head_idx].reg_write;

  // Branch slot below the head index must sit in the next lap
  assign mp_fire = branch_mispredict && valid_q[mispredict_tag];
  assign bm_ptr  = {(mispredict_tag >= head_idx) ? head_q[ROB_TAG_W] : ~head_q[ROB_TAG_W],
                    mispredict_tag};
  // Age of the branch measured from the head
  assign bm_off  = mispredict_tag - head_idx;

  // Next-state for pointers and the valid/done vectors
  always_comb begin
    rob_tag_t slot_off;
    slot_off = '0;
    head_d   = head_q;
    tail_d   = tail_q;
    valid_d  = valid_q;
    done_d   = done_q;

    if (wb_valid && valid_q[wb_tag]) begin
      done_d[wb_tag] = 1'b1;
    end

    if (commit_en) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + rob_ptr_t'(1);
    end

    if (mp_fire) begin
      tail_d = bm_ptr + rob_ptr_t'(1);
      // Squash is applied after wb so a same-cycle wb to a squashed tag is dropped
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        slot_off = rob_tag_t'(i) - head_idx;
        if (slot_off > bm_off) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
    end else if (dispatch_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + rob_ptr_t'(1);
    end
  end

  // Pointer and status state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload storage; contents are only meaningful while the valid bit is set
  always_ff @(posedge clk) begin
    if (dispatch_fire) begin
      entries_q[tail_idx] <= '{pc:        dispatch_pc,
                               rd:        dispatch_rd,
                               prd:       dispatch_prd,
                               old_prd:   dispatch_old_prd,
                               reg_write: dispatch_reg_write};
    end
  end

`ifdef ROB_STATS_EN
  // Free-running performance counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_commit_cnt     <= '0;
      perf_full_stall_cnt <= '0;
    end else begin
      if (commit_en) begin
        perf_commit_cnt <= perf_commit_cnt + 32'd1;
      end
      if (dispatch_valid && rob_full) begin
        perf_full_stall_cnt <= perf_full_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
